// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame constants used by
// both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  localparam int UART_DATA_BITS        = 8;
  localparam int UART_MIN_CLKS_PER_BIT = 4;
  localparam int UART_FRAME_BITS       = 10;

endpackage

// File: rtl/uart_tx_hold.sv
// One-byte holding register between the byte source and the transmit FSM.
// Tracks empty/full (tx_ready) and flags bytes offered while full (tx_ovr).
module uart_tx_hold
  import uart_pkg::*;
(
  input  logic                      i_Clock,
  input  logic                      i_Rst_L,
  input  logic                      tx_dv,
  input  logic [UART_DATA_BITS-1:0] tx_byte,
  input  logic                      take,
  output logic                      tx_ready,
  output logic                      tx_ovr,
  output logic [UART_DATA_BITS-1:0] hold_byte
);

  logic                      ready_r;
  logic                      ovr_r;
  logic [UART_DATA_BITS-1:0] hold_byte_r;

  // Accept into an empty holder, release on take; a byte offered while full is dropped.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      ready_r     <= 1'b1;
      ovr_r       <= 1'b0;
      hold_byte_r <= {UART_DATA_BITS{1'b0}};
    end else begin
      ovr_r <= tx_dv & ~ready_r;
      if (tx_dv && ready_r) begin
        ready_r     <= 1'b0;
        hold_byte_r <= tx_byte;
      end else if (take) begin
        ready_r <= 1'b1;
      end else begin
        ready_r <= ready_r;
      end
    end
  end

  assign tx_ready  = ready_r;
  assign tx_ovr    = ovr_r;
  assign hold_byte = hold_byte_r;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with runtime bit period and a one-byte holding
// register so consecutive frames leave with no idle gap.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_CNT_W = 12
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  input  logic [CLK_CNT_W-1:0] i_Clks_Per_Bit,
  input  logic                 i_Tx_DV,
  input  logic [7:0]           i_Tx_Byte,
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Done,
  output logic                 o_Tx_Ovr
);

  uart_state_e                 state_r;
  logic [CLK_CNT_W-1:0]        cnt_r;
  logic [CLK_CNT_W-1:0]        period_r;
  logic [2:0]                  bit_idx_r;
  logic [UART_DATA_BITS-1:0]   shift_r;
  logic                        serial_r;
  logic                        active_r;
  logic                        done_r;

  logic                        take_s;
  logic                        last_s;
  logic                        pre_last_s;
  logic [CLK_CNT_W-1:0]        clamp_s;
  logic [UART_DATA_BITS-1:0]   hold_byte_s;
  logic                        ready_s;
  logic                        ovr_s;

  uart_tx_hold u_hold (
    .i_Clock   (i_Clock),
    .i_Rst_L   (i_Rst_L),
    .tx_dv     (i_Tx_DV),
    .tx_byte   (i_Tx_Byte),
    .take      (take_s),
    .tx_ready  (ready_s),
    .tx_ovr    (ovr_s),
    .hold_byte (hold_byte_s)
  );

  // Bit-end detection, period clamp and the holder take strobe.
  always_comb begin
    last_s     = (cnt_r == (period_r - CLK_CNT_W'(1)));
    pre_last_s = (cnt_r == (period_r - CLK_CNT_W'(2)));
    if (i_Clks_Per_Bit < CLK_CNT_W'(UART_MIN_CLKS_PER_BIT)) begin
      clamp_s = CLK_CNT_W'(UART_MIN_CLKS_PER_BIT);
    end else begin
      clamp_s = i_Clks_Per_Bit;
    end
    case (state_r)
      UART_IDLE: take_s = ~ready_s;
      UART_STOP: take_s = last_s & ~ready_s;
      default:   take_s = 1'b0;
    endcase
  end

  // Frame FSM; Done is set one cycle early so it is high on the last stop-bit clock.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_r   <= UART_IDLE;
      cnt_r     <= {CLK_CNT_W{1'b0}};
      period_r  <= CLK_CNT_W'(UART_MIN_CLKS_PER_BIT);
      bit_idx_r <= 3'd0;
      shift_r   <= {UART_DATA_BITS{1'b0}};
      serial_r  <= 1'b1;
      active_r  <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        UART_IDLE: begin
          serial_r <= 1'b1;
          active_r <= 1'b0;
          if (take_s) begin
            shift_r  <= hold_byte_s;
            period_r <= clamp_s;
            cnt_r    <= {CLK_CNT_W{1'b0}};
            serial_r <= 1'b0;
            active_r <= 1'b1;
            state_r  <= UART_START;
          end
        end
        UART_START: begin
          if (last_s) begin
            cnt_r     <= {CLK_CNT_W{1'b0}};
            bit_idx_r <= 3'd0;
            serial_r  <= shift_r[0];
            state_r   <= UART_DATA;
          end else begin
            cnt_r <= cnt_r + CLK_CNT_W'(1);
          end
        end
        UART_DATA: begin
          if (last_s) begin
            cnt_r <= {CLK_CNT_W{1'b0}};
            if (bit_idx_r == 3'd7) begin
              serial_r <= 1'b1;
              state_r  <= UART_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              serial_r  <= shift_r[bit_idx_r + 3'd1];
            end
          end else begin
            cnt_r <= cnt_r + CLK_CNT_W'(1);
          end
        end
        UART_STOP: begin
          done_r <= pre_last_s;
          if (last_s) begin
            cnt_r <= {CLK_CNT_W{1'b0}};
            if (take_s) begin
              shift_r  <= hold_byte_s;
              period_r <= clamp_s;
              serial_r <= 1'b0;
              state_r  <= UART_START;
            end else begin
              active_r <= 1'b0;
              state_r  <= UART_IDLE;
            end
          end else begin
            cnt_r <= cnt_r + CLK_CNT_W'(1);
          end
        end
        default: begin
          serial_r <= 1'b1;
          active_r <= 1'b0;
          state_r  <= UART_IDLE;
        end
      endcase
    end
  end

  assign o_Tx_Ready  = ready_s;
  assign o_Tx_Ovr    = ovr_s;
  assign o_Tx_Active = active_r;
  assign o_Tx_Serial = serial_r;
  assign o_Tx_Done   = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a frame-position reference model checked every cycle,
// plus directed literal checks and a randomized traffic phase.
module tb_uart_tx;

  logic        i_Clock = 1'b0;
  logic        i_Rst_L = 1'b0;
  logic [11:0] i_Clks_Per_Bit = 12'd8;
  logic        i_Tx_DV = 1'b0;
  logic [7:0]  i_Tx_Byte = 8'h00;
  logic        o_Tx_Ready, o_Tx_Active, o_Tx_Serial, o_Tx_Done, o_Tx_Ovr;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Reference model state: holder, and position n (clocks) inside the current frame.
  bit         m_full = 1'b0;
  logic [7:0] m_hold = 8'h00;
  bit         m_act  = 1'b0;
  int         m_n    = 0;
  int         m_p    = 4;
  logic [7:0] m_byte = 8'h00;
  logic       e_serial = 1'b1, e_ready = 1'b1, e_active = 1'b0, e_done = 1'b0, e_ovr = 1'b0;

  uart_tx #(.CLK_CNT_W(12)) dut (
    .i_Clock        (i_Clock),
    .i_Rst_L        (i_Rst_L),
    .i_Clks_Per_Bit (i_Clks_Per_Bit),
    .i_Tx_DV        (i_Tx_DV),
    .i_Tx_Byte      (i_Tx_Byte),
    .o_Tx_Ready     (o_Tx_Ready),
    .o_Tx_Active    (o_Tx_Active),
    .o_Tx_Serial    (o_Tx_Serial),
    .o_Tx_Done      (o_Tx_Done),
    .o_Tx_Ovr       (o_Tx_Ovr)
  );

  always #5 i_Clock = ~i_Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    else if (idx >= 9) return 1'b1;
    else return b[idx-1];
  endfunction

  task automatic model_step();
    bit pre_full;
    bit take;
    int p;
    pre_full = m_full;
    take = 1'b0;
    if (!i_Rst_L) begin
      m_full = 1'b0; m_act = 1'b0; m_n = 0;
      e_serial = 1'b1; e_ready = 1'b1; e_active = 1'b0; e_done = 1'b0; e_ovr = 1'b0;
      return;
    end
    e_ovr = i_Tx_DV && pre_full;
    if (m_act) begin
      m_n++;
      if (m_n == 10 * m_p) m_act = 1'b0;
    end
    if (!m_act && pre_full) begin
      p = int'(i_Clks_Per_Bit);
      m_p = (p < 4) ? 4 : p;
      m_act = 1'b1; m_n = 0; m_byte = m_hold; take = 1'b1;
    end
    if (i_Tx_DV && !pre_full) begin
      m_full = 1'b1; m_hold = i_Tx_Byte;
    end else if (take) begin
      m_full = 1'b0;
    end
    e_serial = m_act ? frame_bit(m_byte, m_n / m_p) : 1'b1;
    e_ready  = !m_full;
    e_active = m_act;
    e_done   = m_act && (m_n == 10 * m_p - 1);
  endtask

  initial forever begin
    @(posedge i_Clock);
    model_step();
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge i_Clock);
    if (cmp_en && i_Rst_L) begin
      check("serial", o_Tx_Serial, e_serial);
      check("ready",  o_Tx_Ready,  e_ready);
      check("active", o_Tx_Active, e_active);
      check("done",   o_Tx_Done,   e_done);
      check("ovr",    o_Tx_Ovr,    e_ovr);
    end
  end

  // Waits (bounded) for Ready, offers one byte, returns at the negedge after the accept edge.
  task automatic send(input logic [7:0] b);
    int w = 0;
    while (!o_Tx_Ready && w < 3000) begin
      @(negedge i_Clock); w++;
    end
    check("ready_wait", o_Tx_Ready, 1'b1);
    i_Tx_DV = 1'b1; i_Tx_Byte = b;
    @(negedge i_Clock);
    i_Tx_DV = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    while (!(o_Tx_Ready && !o_Tx_Active) && w < 5000) begin
      @(negedge i_Clock); w++;
    end
    check("idle_wait", o_Tx_Ready && !o_Tx_Active, 1'b1);
  endtask

  initial begin
    logic [9:0] a5_frame;
    int d0, d1;
    a5_frame = 10'b1101001010;

    repeat (3) @(negedge i_Clock);
    check("rst_serial", o_Tx_Serial, 1'b1);
    check("rst_ready",  o_Tx_Ready,  1'b1);
    check("rst_active", o_Tx_Active, 1'b0);
    check("rst_done",   o_Tx_Done,   1'b0);
    check("rst_ovr",    o_Tx_Ovr,    1'b0);
    #1 i_Rst_L = 1'b1;
    cmp_en = 1'b1;

    // Single byte 0xA5 at P=8, pinned against literal bit levels and Done position.
    send(8'hA5);
    for (int m = 1; m <= 82; m++) begin
      @(negedge i_Clock);
      if (m <= 80 && ((m - 1) % 8) == 3) check("a5_bit", o_Tx_Serial, a5_frame[(m - 1) / 8]);
      if (m == 79 || m == 81) check("a5_done_low", o_Tx_Done, 1'b0);
      if (m == 80) check("a5_done_high", o_Tx_Done, 1'b1);
    end
    wait_idle();

    // Back-to-back 0x00 then 0xFF: two Done pulses exactly one frame apart.
    send(8'h00);
    send(8'hFF);
    d0 = -1; d1 = -1;
    for (int c = 0; c < 200; c++) begin
      @(negedge i_Clock);
      if (o_Tx_Done) begin
        if (d0 < 0) d0 = c; else d1 = c;
      end
    end
    check("b2b_done_gap", d1 - d0, 80);
    wait_idle();

    // Overrun: frame active and holder full, then offer 0x3C.
    send(8'h11);
    send(8'h22);
    i_Tx_DV = 1'b1; i_Tx_Byte = 8'h3C;
    @(negedge i_Clock);
    i_Tx_DV = 1'b0;
    check("ovr_pulse", o_Tx_Ovr, 1'b1);
    @(negedge i_Clock);
    check("ovr_single", o_Tx_Ovr, 1'b0);
    wait_idle();

    // Reset during data bit 3, then a clean 0x81 frame.
    send(8'h5A);
    repeat (35) @(negedge i_Clock);
    #1 i_Rst_L = 1'b0;
    #1;
    check("mid_rst_serial", o_Tx_Serial, 1'b1);
    check("mid_rst_ready",  o_Tx_Ready,  1'b1);
    check("mid_rst_active", o_Tx_Active, 1'b0);
    repeat (3) begin
      @(negedge i_Clock);
      check("mid_rst_done", o_Tx_Done, 1'b0);
    end
    #1 i_Rst_L = 1'b1;
    send(8'h81);
    wait_idle();

    // Period latch: P=87 frame ignores a mid-frame change to 16.
    i_Clks_Per_Bit = 12'd87;
    send(8'h55);
    for (int m = 1; m <= 349; m++) begin
      @(negedge i_Clock);
      if (m == 300) i_Clks_Per_Bit = 12'd16;
      if (m == 348) check("p87_bit2_end", o_Tx_Serial, 1'b1);
      if (m == 349) check("p87_bit3_start", o_Tx_Serial, 1'b0);
    end
    wait_idle();
    send(8'h0F);
    for (int m = 1; m <= 17; m++) begin
      @(negedge i_Clock);
      if (m == 16) check("p16_start_end", o_Tx_Serial, 1'b0);
      if (m == 17) check("p16_bit0", o_Tx_Serial, 1'b1);
    end
    wait_idle();
    i_Clks_Per_Bit = 12'd2;
    send(8'hC3);
    for (int m = 1; m <= 5; m++) begin
      @(negedge i_Clock);
      if (m == 4) check("clamp_start_end", o_Tx_Serial, 1'b0);
      if (m == 5) check("clamp_bit0", o_Tx_Serial, 1'b1);
    end
    wait_idle();

    // Randomized traffic with occasional period changes (including clamped values).
    for (int c = 0; c < 4000; c++) begin
      i_Tx_DV   = ($urandom_range(0, 5) == 0);
      i_Tx_Byte = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 99) == 0) i_Clks_Per_Bit = 12'($urandom_range(0, 12));
      @(negedge i_Clock);
    end
    i_Tx_DV = 1'b0;
    wait_idle();
    repeat (2) @(negedge i_Clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter: serialises bytes as 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) on a line that idles high.
- Bit period is a runtime input in clocks, so it pairs with uart_rx on the same baud setting.
- A one-byte holding register accepts the next byte while the current frame is being sent, so frames go out back-to-back with no idle gap.
- Sits between the FIFO read side and the board TX pin.

Parameters:
- CLK_CNT_W, 12: width of i_Clks_Per_Bit and of the internal bit-period counter.

Ports:
- i_Clock  in  1  system clock; all logic is on its rising edge.
- i_Rst_L  in  1  asynchronous active-low reset.
- i_Clks_Per_Bit  in  CLK_CNT_W  clocks per bit, = f_clk/baud (e.g. 87 for 10 MHz / 115200).
- i_Tx_DV  in  1  byte valid; the byte is accepted on an edge where i_Tx_DV=1 and o_Tx_Ready=1.
- i_Tx_Byte  in  8  byte to send; sampled only on accept.
- o_Tx_Ready  out  1  holding register empty.
- o_Tx_Active  out  1  a frame is in progress (states START/DATA/STOP).
- o_Tx_Serial  out  1  serial line.
- o_Tx_Done  out  1  one-cycle pulse on the last cycle of each stop bit.
- o_Tx_Ovr  out  1  one-cycle pulse when i_Tx_DV=1 while o_Tx_Ready=0; that byte is dropped.

Behaviour:
- **Reset (asynchronous, immediate):**
  - o_Tx_Serial=1, o_Tx_Ready=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Ovr=0.
  - FSM=IDLE, holding register empty, counters cleared.
  - Reset mid-frame truncates the frame and the line returns high at once.
- **Holding register:**
  - Loads on accept.
  - Empties on the edge where the FSM takes the byte.
  - o_Tx_Ready is a register and reflects "empty" after that edge.
  - If a take and i_Tx_DV coincide while Ready=0, the DV is dropped and o_Tx_Ovr pulses. No same-cycle pass-through.
- **Bit period latch:** i_Clks_Per_Bit is latched into a period register when a frame starts. Changing it mid-frame has no effect until the next frame. Latched values below 4 are clamped to 4.
- **FSM states: IDLE, START, DATA, STOP.**
  - IDLE:
    - Serial=1.
    - If the holding register is full: load the shift register from it, empty it, clear the counter, serial<=0, go to START.
  - START:
    - Serial=0 for exactly P clocks (P = latched period); the counter runs 0..P-1.
    - Then serial<=bit0, bit index=0, go to DATA.
  - DATA:
    - Each bit is held P clocks.
    - After bit index 7, serial<=1 and go to STOP.
    - The index is 3 bits and does not wrap past 7.
  - STOP:
    - Serial=1 for P clocks; o_Tx_Done=1 on the final cycle.
    - Then, if the holding register is full, take the byte, serial<=0 and go directly to START (back-to-back). Otherwise go to IDLE.
- **Latency:**
  - Accept at edge k while IDLE: o_Tx_Serial falls after edge k+1.
  - The frame occupies exactly 10*P clocks.
  - o_Tx_Done is high during the last of those clocks.
- All outputs are registered. Counter compare is the equality counter==P-1 at CLK_CNT_W width; there is no arithmetic overflow because P ≤ 2^CLK_CNT_W-1.
- o_Tx_Active=1 throughout START/DATA/STOP, including across back-to-back frames.

Decomposition:
- Shared package uart_pkg:
  - FSM state encodings (shared with uart_rx states where applicable).
  - UART_DATA_BITS=8.
  - UART_MIN_CLKS_PER_BIT=4.
  - Frame length constant 10.
- Sub-module uart_tx_hold: holding register with the Ready/Ovr logic (accept, take, drop). The FSM, bit counter and shifter stay in uart_tx.

Test Plan:
- Single byte: P=8, send 0xA5 while idle. Serial goes low the cycle after the accept edge+1 and reads 0,1,0,1,0,0,1,0,1,1, each level exactly 8 clocks. o_Tx_Done pulses once at clock 80. A uart_rx instance with the same P outputs 0xA5.
- Back-to-back: P=8, send 0x00, then 0xFF as soon as Ready returns. The 20 bit-times are contiguous, o_Tx_Active never drops, two Done pulses 80 clocks apart, and the loopback receiver yields 0x00 then 0xFF.
- Overrun: P=8, with a frame active and the holder full, pulse DV with 0x3C. o_Tx_Ovr pulses for 1 cycle, 0x3C is never transmitted, and the queued byte is sent intact.
- Mid-frame reset: assert i_Rst_L=0 during DATA bit 3. Serial=1 and Ready=1 immediately, with no Done pulse. After release, sending 0x81 produces a correct full frame.
- Period change and clamp:
  - Frame with P=87 sends 0x55; changing i_Clks_Per_Bit to 16 mid-frame leaves the bit lengths at 87.
  - The next frame uses 16.
  - Setting 2 yields 4-clock bits.
